// File: rtl/phase_sched_pkg.sv
// phase_sched_pkg: shared default widths, watchdog limit and FSM
// encoding for the phase_cordic_scheduler slice.
package phase_sched_pkg;

    localparam int DEF_FFT_W       = 28;
    localparam int DEF_FRAC_W      = 3;
    localparam int DEF_CORDIC_W    = 32;
    localparam int DEF_PHASE_W     = 16;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ISSUE_V = 3'd1;
    localparam state_t S_WAIT_V  = 3'd2;
    localparam state_t S_ISSUE_I = 3'd3;
    localparam state_t S_WAIT_I  = 3'd4;
    localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/phase_cordic_scheduler_sm2tc.sv
// phase_sm2tc: FFT peak word (sign-magnitude, fractional bits dropped)
// to CORDIC operand (two's complement); negative zero maps to 0.
module phase_sm2tc
    import phase_sched_pkg::*;
#(
    parameter int FFT_W    = DEF_FFT_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int CORDIC_W = DEF_CORDIC_W
) (
    input  logic [FFT_W-1:0]    sm,
    output logic [CORDIC_W-1:0] tc
);

    localparam int MAG_W = FFT_W - 1 - FRAC_W;

    logic [CORDIC_W-1:0] mag;
    logic                unused_frac;

    assign mag         = {{(CORDIC_W-MAG_W){1'b0}}, sm[FFT_W-2:FRAC_W]};
    assign tc          = sm[FFT_W-1] ? -mag : mag;
    assign unused_frac = ^sm[FRAC_W-1:0];

endmodule

// File: rtl/phase_cordic_scheduler.sv
// phase_cordic_scheduler: pairs V/I FFT peaks and time-shares one CORDIC.
// Optional build macro IDX_CHECK_EN adds the peak-bin match check.
module phase_cordic_scheduler
    import phase_sched_pkg::*;
#(
    parameter int FFT_W       = DEF_FFT_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int CORDIC_W    = DEF_CORDIC_W,
    parameter int PHASE_W     = DEF_PHASE_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk_1M,
    input  logic                rst,
    input  logic                en,
    input  logic                peak_vld_v,
    input  logic [FFT_W-1:0]    peak_re_v,
    input  logic [FFT_W-1:0]    peak_im_v,
    input  logic [9:0]          peak_idx_v,
    input  logic                peak_vld_i,
    input  logic [FFT_W-1:0]    peak_re_i,
    input  logic [FFT_W-1:0]    peak_im_i,
    input  logic [9:0]          peak_idx_i,
    output logic [CORDIC_W-1:0] cordic_x,
    output logic [CORDIC_W-1:0] cordic_y,
    output logic                cordic_start,
    input  logic                cordic_valid,
    input  logic [PHASE_W-1:0]  cordic_phase,
    output logic [PHASE_W-1:0]  phase,
    output logic                phase_vld,
    output logic                busy,
    output logic                timeout_err
`ifdef IDX_CHECK_EN
    ,
    output logic                idx_mismatch
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state;
    logic                flag_v;
    logic                flag_i;
    logic [FFT_W-1:0]    hre_v;
    logic [FFT_W-1:0]    him_v;
    logic [FFT_W-1:0]    hre_i;
    logic [FFT_W-1:0]    him_i;
    logic [CORDIC_W-1:0] tre_v;
    logic [CORDIC_W-1:0] tim_v;
    logic [CORDIC_W-1:0] tre_i;
    logic [CORDIC_W-1:0] tim_i;
    logic [CORDIC_W-1:0] wx_i;
    logic [CORDIC_W-1:0] wy_i;
    logic [PHASE_W-1:0]  ang_v;
    logic [PHASE_W-1:0]  ang_i;
    logic [CNT_W-1:0]    cnt;
    logic                go;
    logic                idx_bad;

    phase_sm2tc #(.FFT_W(FFT_W), .FRAC_W(FRAC_W), .CORDIC_W(CORDIC_W))
        u_re_v (.sm(hre_v), .tc(tre_v));
    phase_sm2tc #(.FFT_W(FFT_W), .FRAC_W(FRAC_W), .CORDIC_W(CORDIC_W))
        u_im_v (.sm(him_v), .tc(tim_v));
    phase_sm2tc #(.FFT_W(FFT_W), .FRAC_W(FRAC_W), .CORDIC_W(CORDIC_W))
        u_re_i (.sm(hre_i), .tc(tre_i));
    phase_sm2tc #(.FFT_W(FFT_W), .FRAC_W(FRAC_W), .CORDIC_W(CORDIC_W))
        u_im_i (.sm(him_i), .tc(tim_i));

`ifdef IDX_CHECK_EN
    logic [9:0] hidx_v;
    logic [9:0] hidx_i;

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            hidx_v <= '0;
            hidx_i <= '0;
        end else if (en) begin
            if (peak_vld_v) hidx_v <= peak_idx_v;
            if (peak_vld_i) hidx_i <= peak_idx_i;
        end
    end

    assign idx_bad = (hidx_v != hidx_i);
`else
    logic unused_idx;

    assign unused_idx = ^{peak_idx_v, peak_idx_i};
    assign idx_bad    = 1'b0;
`endif

    assign go           = (state == S_IDLE) && flag_v && flag_i;
    assign busy         = (state != S_IDLE);
    assign cordic_start = (state == S_ISSUE_V) || (state == S_ISSUE_I);

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            flag_v      <= 1'b0;
            flag_i      <= 1'b0;
            hre_v       <= '0;
            him_v       <= '0;
            hre_i       <= '0;
            him_i       <= '0;
            wx_i        <= '0;
            wy_i        <= '0;
            ang_v       <= '0;
            ang_i       <= '0;
            cnt         <= '0;
            cordic_x    <= '0;
            cordic_y    <= '0;
            phase       <= '0;
            phase_vld   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef IDX_CHECK_EN
            idx_mismatch <= 1'b0;
`endif
        end else if (!en) begin
            state       <= S_IDLE;
            flag_v      <= 1'b0;
            flag_i      <= 1'b0;
            phase_vld   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef IDX_CHECK_EN
            idx_mismatch <= 1'b0;
`endif
        end else begin
            phase_vld <= 1'b0;
`ifdef IDX_CHECK_EN
            idx_mismatch <= 1'b0;
`endif
            if (peak_vld_v) begin
                hre_v <= peak_re_v;
                him_v <= peak_im_v;
            end
            if (peak_vld_i) begin
                hre_i <= peak_re_i;
                him_i <= peak_im_i;
            end
            // a capture in the same cycle as the pairing clear keeps its flag
            flag_v <= peak_vld_v | (flag_v & ~go);
            flag_i <= peak_vld_i | (flag_i & ~go);

            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (idx_bad) begin
`ifdef IDX_CHECK_EN
                            idx_mismatch <= 1'b1;
`endif
                        end else begin
                            state    <= S_ISSUE_V;
                            cordic_x <= tre_v;
                            cordic_y <= tim_v;
                            wx_i     <= tre_i;
                            wy_i     <= tim_i;
                        end
                    end
                end
                S_ISSUE_V: begin
                    state <= S_WAIT_V;
                    cnt   <= '0;
                end
                S_WAIT_V: begin
                    if (cordic_valid) begin
                        ang_v    <= cordic_phase;
                        state    <= S_ISSUE_I;
                        cordic_x <= wx_i;
                        cordic_y <= wy_i;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ISSUE_I: begin
                    state <= S_WAIT_I;
                    cnt   <= '0;
                end
                S_WAIT_I: begin
                    if (cordic_valid) begin
                        ang_i <= cordic_phase;
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    phase     <= ang_v - ang_i;
                    phase_vld <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_cordic_scheduler.sv
// tb_phase_cordic_scheduler: directed and randomized checks of the
// scheduler against a behavioural CORDIC responder and pairing model.
module tb_phase_cordic_scheduler;

    logic        clk_1M = 1'b0;
    logic        rst;
    logic        en;
    logic        peak_vld_v;
    logic [27:0] peak_re_v;
    logic [27:0] peak_im_v;
    logic [9:0]  peak_idx_v;
    logic        peak_vld_i;
    logic [27:0] peak_re_i;
    logic [27:0] peak_im_i;
    logic [9:0]  peak_idx_i;
    logic [31:0] cordic_x;
    logic [31:0] cordic_y;
    logic        cordic_start;
    logic        cordic_valid;
    logic [15:0] cordic_phase;
    logic [15:0] phase;
    logic        phase_vld;
    logic        busy;
    logic        timeout_err;
`ifdef IDX_CHECK_EN
    logic        idx_mismatch;
`endif

    phase_cordic_scheduler dut (
        .clk_1M      (clk_1M),
        .rst         (rst),
        .en          (en),
        .peak_vld_v  (peak_vld_v),
        .peak_re_v   (peak_re_v),
        .peak_im_v   (peak_im_v),
        .peak_idx_v  (peak_idx_v),
        .peak_vld_i  (peak_vld_i),
        .peak_re_i   (peak_re_i),
        .peak_im_i   (peak_im_i),
        .peak_idx_i  (peak_idx_i),
        .cordic_x    (cordic_x),
        .cordic_y    (cordic_y),
        .cordic_start(cordic_start),
        .cordic_valid(cordic_valid),
        .cordic_phase(cordic_phase),
        .phase       (phase),
        .phase_vld   (phase_vld),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef IDX_CHECK_EN
        ,
        .idx_mismatch(idx_mismatch)
`endif
    );

    always #5 clk_1M = ~clk_1M;

    int cyc = 0;
    always @(posedge clk_1M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // CORDIC responder state
    int          lat = 16;
    bit          resp_en = 1'b1;
    bit          tog = 1'b0;
    int          pend = 0;
    logic [15:0] ang_a = '0;
    logic [15:0] ang_b = '0;
    logic [15:0] cur_ang = '0;
    logic [31:0] sx[$];
    logic [31:0] sy[$];
    int          n_start = 0;
    int          n_vld = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference conversion: drop fraction, apply sign arithmetically.
    function automatic logic [31:0] conv(input logic [27:0] w);
        int m;
        m = (int'(w) % (1 << 27)) / 8;
        return w[27] ? 32'(-m) : 32'(m);
    endfunction

    initial begin
        cordic_valid = 1'b0;
        cordic_phase = '0;
        forever begin
            @(negedge clk_1M);
            cordic_valid = 1'b0;
            if (phase_vld === 1'b1) n_vld++;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    cordic_valid = 1'b1;
                    cordic_phase = cur_ang;
                end
            end
            if (cordic_start === 1'b1) begin
                n_start++;
                sx.push_back(cordic_x);
                sy.push_back(cordic_y);
                if (resp_en) begin
                    cur_ang = tog ? ang_b : ang_a;
                    tog     = ~tog;
                    pend    = lat;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1M);
        #2;
    endtask

    task automatic pulse(input bit dv, input bit di,
                         input logic [27:0] rv, input logic [27:0] iv,
                         input logic [27:0] ri, input logic [27:0] ii,
                         input logic [9:0] xv, input logic [9:0] xi);
        @(negedge clk_1M);
        peak_vld_v = dv;
        peak_vld_i = di;
        if (dv) begin
            peak_re_v  = rv;
            peak_im_v  = iv;
            peak_idx_v = xv;
        end
        if (di) begin
            peak_re_i  = ri;
            peak_im_i  = ii;
            peak_idx_i = xi;
        end
        @(negedge clk_1M);
        peak_vld_v = 1'b0;
        peak_vld_i = 1'b0;
    endtask

    task automatic wait_vld(output int at);
        at = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_1M);
            if (phase_vld === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic round(input logic [27:0] rv, input logic [27:0] iv,
                         input logic [27:0] ri, input logic [27:0] ii,
                         input logic [15:0] a, input logic [15:0] b,
                         input int l, input string tag);
        int          c0;
        int          at;
        logic [15:0] exp;
        tog     = 1'b0;
        ang_a   = a;
        ang_b   = b;
        lat     = l;
        resp_en = 1'b1;
        sx.delete();
        sy.delete();
        pulse(1'b1, 1'b1, rv, iv, ri, ii, 10'd5, 10'd5);
        c0 = cyc;
        wait_vld(at);
        exp = a - b;
        check({tag, "_lat"}, 64'(at - c0), 64'(2 * (l + 1) + 2));
        check({tag, "_phase"}, phase, exp);
        @(negedge clk_1M);
        check({tag, "_vld_width"}, phase_vld, 1'b0);
        check({tag, "_nstart"}, sx.size(), 2);
        if (sx.size() == 2) begin
            check({tag, "_vx"}, sx[0], conv(rv));
            check({tag, "_vy"}, sy[0], conv(iv));
            check({tag, "_ix"}, sx[1], conv(ri));
            check({tag, "_iy"}, sy[1], conv(ii));
        end
    endtask

    initial begin
        int          base;
        int          vbase;
        int          at;
        int          cs;
        logic [27:0] d [3];
        logic [15:0] keep;

        rst = 1'b0;
        en = 1'b0;
        peak_vld_v = 1'b0;
        peak_vld_i = 1'b0;
        peak_re_v = '0;
        peak_im_v = '0;
        peak_idx_v = '0;
        peak_re_i = '0;
        peak_im_i = '0;
        peak_idx_i = '0;

        #3;
        check("rst_phase", phase, 16'h0);
        check("rst_vld", phase_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", cordic_start, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);
        check("rst_cx", cordic_x, 32'h0);

        @(negedge clk_1M);
        rst = 1'b1;
        en  = 1'b1;
        idle(2);

        round(28'h0001F40, 28'h0, 28'h0001F40, 28'h0,
              16'h2000, 16'h0000, 16, "basic");
        check("basic_const", phase, 16'h2000);

        round(28'h0001F40, 28'h0, 28'h0001F40, 28'h0,
              16'h7000, 16'h9000, 16, "wrap");
        check("wrap_const", phase, 16'hE000);

        round(28'h8001F40, 28'h0000010, 28'h8000000, 28'h8000008,
              16'h1234, 16'h0F00, 8, "sign");
        if (sx.size() == 2) begin
            check("sign_neg", sx[0], 32'hFFFFFC18);
            check("sign_negzero", sx[1], 32'h0);
        end

        for (int r = 0; r < 5; r++) begin
            round(28'($urandom), 28'($urandom), 28'($urandom),
                  28'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(1, 20)), "rand");
        end

        // pairing: newest V wins, no start until I arrives
        idle(1);
        base = n_start;
        vbase = n_vld;
        for (int k = 0; k < 3; k++) begin
            d[k] = 28'($urandom);
            pulse(1'b1, 1'b0, d[k], 28'h10, 28'h0, 28'h0, 10'd1, 10'd1);
            idle(3);
        end
        idle(20);
        check("pair_nostart", n_start, base);
        tog = 1'b0;
        ang_a = 16'h4000;
        ang_b = 16'h1000;
        lat = 10;
        sx.delete();
        sy.delete();
        pulse(1'b0, 1'b1, 28'h0, 28'h0, 28'h0000400, 28'h0, 10'd1, 10'd1);
        wait_vld(at);
        check("pair_phase", phase, 16'h3000);
        if (sx.size() > 0) check("pair_third", sx[0], conv(d[2]));
        idle(40);
        check("pair_one_round", n_start, base + 2);
        check("pair_one_vld", n_vld, vbase + 1);

        // capture coinciding with the pairing edge is held for next round
        tog = 1'b0;
        ang_a = 16'h0100;
        ang_b = 16'h0080;
        lat = 4;
        sx.delete();
        sy.delete();
        d[0] = 28'h0000800;
        d[1] = 28'h8000C00;
        @(negedge clk_1M);
        peak_vld_v = 1'b1;
        peak_vld_i = 1'b1;
        peak_re_v = d[0];
        peak_im_v = '0;
        peak_re_i = 28'h0000100;
        peak_im_i = '0;
        @(negedge clk_1M);
        peak_vld_i = 1'b0;
        peak_re_v = d[1];
        @(negedge clk_1M);
        peak_vld_v = 1'b0;
        wait_vld(at);
        check("race_first", (sx.size() > 0) ? sx[0] : 32'hDEAD, conv(d[0]));
        idle(5);
        tog = 1'b0;
        pulse(1'b0, 1'b1, 28'h0, 28'h0, 28'h0000100, 28'h0, 10'd1, 10'd1);
        wait_vld(at);
        check("race_second", (sx.size() > 2) ? sx[2] : 32'hDEAD, conv(d[1]));

        // watchdog
        idle(5);
        resp_en = 1'b0;
        vbase = n_vld;
        pulse(1'b1, 1'b1, 28'h10, 28'h10, 28'h10, 28'h10, 10'd1, 10'd1);
        cs = -1;
        for (int n = 0; n < 20; n++) begin
            if (cordic_start === 1'b1) begin
                cs = cyc;
                break;
            end
            @(negedge clk_1M);
        end
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_1M);
            if (timeout_err === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check("tmo_lat", 64'(at - cs), 64'd65);
        check("tmo_idle", busy, 1'b0);
        idle(80);
        check("tmo_novld", n_vld, vbase);
        check("tmo_sticky", timeout_err, 1'b1);
        @(negedge clk_1M);
        en = 1'b0;
        @(negedge clk_1M);
        check("tmo_clear", timeout_err, 1'b0);
        en = 1'b1;
        resp_en = 1'b1;

        // captures while disabled, and flags cleared by en low
        base = n_start;
        en = 1'b0;
        pulse(1'b1, 1'b1, 28'h10, 28'h10, 28'h10, 28'h10, 10'd1, 10'd1);
        en = 1'b1;
        idle(30);
        check("en_ignore", n_start, base);
        pulse(1'b1, 1'b0, 28'h10, 28'h10, 28'h0, 28'h0, 10'd1, 10'd1);
        en = 1'b0;
        @(negedge clk_1M);
        en = 1'b1;
        pulse(1'b0, 1'b1, 28'h0, 28'h0, 28'h10, 28'h10, 10'd1, 10'd1);
        idle(30);
        check("en_flag_clear", n_start, base);

        // abort by en during WAIT_I
        keep = phase;
        vbase = n_vld;
        tog = 1'b0;
        ang_a = 16'h5555;
        ang_b = 16'h1111;
        lat = 16;
        base = n_start;
        pulse(1'b1, 1'b1, 28'h80, 28'h80, 28'h80, 28'h80, 10'd1, 10'd1);
        for (int n = 0; n < 100 && n_start < base + 2; n++) begin
            @(negedge clk_1M);
        end
        repeat (5) @(negedge clk_1M);
        check("abort_en_busy_pre", busy, 1'b1);
        en = 1'b0;
        @(negedge clk_1M);
        check("abort_en_busy", busy, 1'b0);
        en = 1'b1;
        idle(40);
        check("abort_en_novld", n_vld, vbase);
        check("abort_en_phase", phase, keep);

        // abort by asynchronous reset during WAIT_I
        tog = 1'b0;
        base = n_start;
        pulse(1'b1, 1'b1, 28'h80, 28'h80, 28'h80, 28'h80, 10'd1, 10'd1);
        for (int n = 0; n < 100 && n_start < base + 2; n++) begin
            @(negedge clk_1M);
        end
        repeat (5) @(negedge clk_1M);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rst_busy", busy, 1'b0);
        check("abort_rst_phase", phase, 16'h0);
        check("abort_rst_start", cordic_start, 1'b0);
        @(negedge clk_1M);
        rst = 1'b1;
        idle(40);
        check("abort_rst_novld", n_vld, vbase);

`ifdef IDX_CHECK_EN
        base = n_start;
        pulse(1'b1, 1'b1, 28'h80, 28'h80, 28'h80, 28'h80, 10'd12, 10'd13);
        @(negedge clk_1M);
        check("idx_pulse", idx_mismatch, 1'b1);
        check("idx_idle", busy, 1'b0);
        @(negedge clk_1M);
        check("idx_pulse_end", idx_mismatch, 1'b0);
        idle(20);
        check("idx_nostart", n_start, base);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
